nib_serial_rx: RTL and testbench

- Serial frame receiver for the 4-bit datapath.
- Recovers one nibble per frame from a single-wire, bit-strobed line and checks framing and parity.
- Presents the nibble on a registered valid/ready output port.
- It is the receive end of the nibble serial link; the transmit end drives SIN one bit per BIT_EN strobe.

---
 rtl/nib_serial_rx.sv | 141 ++++++++++++++
 tb/tb_nib_serial_rx.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nib_serial_rx.sv
// Nibble serial link receiver: start bit, DATA_W data bits LSB first,
// optional parity bit and stop bit, delivered on a valid/ready port.
module nib_serial_rx #(
    parameter int DATA_W     = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              SIN,
    input  logic              BIT_EN,
    output logic [DATA_W-1:0] DOUT,
    output logic              DVALID,
    input  logic              DREADY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVR,
    output logic              BUSY
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              bad_q, bad_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            bad_q    <= 1'b0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            bad_q    <= bad_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        par_d    = par_q;
        bad_d    = bad_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        if (dvalid_q && DREADY) begin
            dvalid_d = 1'b0;
        end

        if (BIT_EN) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!SIN) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                        bad_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    sh_d             = sh_q >> 1;
                    sh_d[DATA_W-1]   = SIN;
                    par_d            = par_q ^ SIN;
                    cnt_d            = cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        state_d = PARITY_EN ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    bad_d   = (par_q ^ SIN) != PARITY_ODD;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (!SIN) begin
                        // framing error wins over parity
                        ferr_d  = 1'b1;
                        state_d = S_BRK;
                    end else begin
                        state_d = S_IDLE;
                        if (bad_q) begin
                            perr_d = 1'b1;
                        end else if (!dvalid_q || DREADY) begin
                            dout_d   = sh_q;
                            dvalid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    if (SIN) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign PERR   = perr_q;
    assign FERR   = ferr_q;
    assign OVR    = ovr_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_nib_serial_rx.sv
// Bench for nib_serial_rx: directed scenarios plus random frames
// checked cycle by cycle against a frame-level reference model.
module tb_nib_serial_rx;

    logic       CLK = 1'b0;
    logic       RN = 1'b0;
    logic       SIN = 1'b1;
    logic       BIT_EN = 1'b0;
    logic       DREADY = 1'b0;
    logic [3:0] DOUT;
    logic       DVALID, PERR, FERR, OVR, BUSY;

    nib_serial_rx dut (
        .CLK(CLK), .RN(RN), .SIN(SIN), .BIT_EN(BIT_EN),
        .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
        .PERR(PERR), .FERR(FERR), .OVR(OVR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    localparam int EV_NONE = 0;
    localparam int EV_GOOD = 1;
    localparam int EV_PERR = 2;
    localparam int EV_FERR = 3;

    typedef struct {
        logic       sin;
        logic       en;
        int         ev;
        logic       busy;
        logic [3:0] d;
    } ent_t;

    ent_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    logic       m_valid = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_busy = 1'b0;
    logic [3:0] m_dout = 4'h0;

    int s_busy, s_dv, s_perr, s_ferr, s_ovr;
    logic [3:0] s_dout;

    task automatic clr_stats();
        s_busy = 0; s_dv = 0; s_perr = 0;
        s_ferr = 0; s_ovr = 0; s_dout = 4'h0;
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
        m_ovr = 1'b0; m_busy = 1'b0; m_dout = 4'h0;
    endtask

    task automatic clk_step(input ent_t e, input logic rdy);
        int   ev;
        logic room;
        SIN    = e.sin;
        BIT_EN = e.en;
        DREADY = rdy;
        ev   = e.en ? e.ev : EV_NONE;
        room = !m_valid || rdy;
        if (m_valid && rdy) m_valid = 1'b0;
        if (ev == EV_GOOD && room) begin
            m_valid = 1'b1;
            m_dout  = e.d;
        end
        m_ovr  = (ev == EV_GOOD) && !room;
        m_perr = (ev == EV_PERR);
        m_ferr = (ev == EV_FERR);
        if (e.en) m_busy = e.busy;
        @(posedge CLK);
        #1;
        s_busy += int'(BUSY);
        s_dv   += int'(DVALID);
        s_perr += int'(PERR);
        s_ferr += int'(FERR);
        s_ovr  += int'(OVR);
        if (DVALID) s_dout = DOUT;
    endtask

    task automatic push_bit(input logic sin, input int ev,
                            input logic busy, input logic [3:0] d,
                            input int gap);
        ent_t e;
        for (int i = 0; i < gap; i++) begin
            e.sin = ($urandom_range(0, 1) == 1);
            e.en = 1'b0; e.ev = EV_NONE; e.busy = busy; e.d = d;
            q.push_back(e);
        end
        e.sin = sin; e.en = 1'b1; e.ev = ev; e.busy = busy; e.d = d;
        q.push_back(e);
    endtask

    task automatic push_frame(input logic [3:0] d, input logic pbit,
                              input logic sbit, input int gap,
                              input int nlow);
        int ev;
        push_bit(1'b0, EV_NONE, 1'b1, d, gap);
        for (int i = 0; i < 4; i++) push_bit(d[i], EV_NONE, 1'b1, d, gap);
        push_bit(pbit, EV_NONE, 1'b1, d, gap);
        if (!sbit) ev = EV_FERR;
        else if ((($countones(d) + int'(pbit)) % 2) == 0) ev = EV_GOOD;
        else ev = EV_PERR;
        push_bit(sbit, ev, !sbit, d, gap);
        if (!sbit) begin
            for (int i = 0; i < nlow; i++) push_bit(1'b0, EV_NONE, 1'b1, d, gap);
            push_bit(1'b1, EV_NONE, 1'b0, d, gap);
        end
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_bit(1'b1, EV_NONE, 1'b0, 4'h0, 0);
    endtask

    task automatic run_q(input logic rdy);
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            clk_step(e, rdy);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        model_reset();
        push_idle(3);
        run_q(1'b1);
        n_chk++;
        if ({DOUT, DVALID, PERR, FERR, OVR, BUSY} !== 9'h0)
            $display("FAIL reset_outs got %h want 000",
                     {DOUT, DVALID, PERR, FERR, OVR, BUSY});
        else n_pass++;
        RN = 1'b1;
        push_idle(2);
        run_q(1'b1);
        n_chk++;
        if ({DVALID, BUSY} !== 2'b00)
            $display("FAIL reset_idle got %b want 00", {DVALID, BUSY});
        else n_pass++;
    endtask

    task automatic test_good();
        clr_stats();
        push_frame(4'hB, 1'b1, 1'b1, 0, 0);
        push_idle(3);
        run_q(1'b1);
        n_chk++;
        if (s_busy !== 6) $display("FAIL good_busy got %0d want 6", s_busy);
        else n_pass++;
        n_chk++;
        if (s_dv !== 1) $display("FAIL good_dvcycles got %0d want 1", s_dv);
        else n_pass++;
        n_chk++;
        if (s_dout !== 4'hB) $display("FAIL good_dout got %h want b", s_dout);
        else n_pass++;
        n_chk++;
        if (s_perr + s_ferr + s_ovr !== 0)
            $display("FAIL good_errs got %0d want 0", s_perr + s_ferr + s_ovr);
        else n_pass++;
    endtask

    task automatic test_parity();
        clr_stats();
        push_frame(4'hB, 1'b0, 1'b1, 0, 0);
        push_idle(3);
        run_q(1'b1);
        n_chk++;
        if (s_perr !== 1) $display("FAIL par_perr got %0d want 1", s_perr);
        else n_pass++;
        n_chk++;
        if (s_dv !== 0) $display("FAIL par_dv got %0d want 0", s_dv);
        else n_pass++;
        n_chk++;
        if (DOUT !== 4'hB) $display("FAIL par_dout got %h want b", DOUT);
        else n_pass++;
        n_chk++;
        if (s_ferr + s_ovr !== 0)
            $display("FAIL par_other got %0d want 0", s_ferr + s_ovr);
        else n_pass++;
    endtask

    task automatic test_break();
        clr_stats();
        push_frame(4'h5, 1'b0, 1'b0, 0, 10);
        run_q(1'b1);
        n_chk++;
        if (s_busy !== 17) $display("FAIL brk_busy got %0d want 17", s_busy);
        else n_pass++;
        n_chk++;
        if (BUSY !== 1'b0) $display("FAIL brk_release got %b want 0", BUSY);
        else n_pass++;
        push_idle(3);
        run_q(1'b1);
        n_chk++;
        if (s_ferr !== 1) $display("FAIL brk_ferr got %0d want 1", s_ferr);
        else n_pass++;
        n_chk++;
        if (s_perr + s_dv + s_ovr !== 0)
            $display("FAIL brk_other got %0d want 0", s_perr + s_dv + s_ovr);
        else n_pass++;
    endtask

    task automatic test_overrun();
        clr_stats();
        push_frame(4'h3, 1'b0, 1'b1, 0, 0);
        push_frame(4'hC, 1'b0, 1'b1, 0, 0);
        run_q(1'b0);
        n_chk++;
        if (OVR !== 1'b1) $display("FAIL ovr_edge got %b want 1", OVR);
        else n_pass++;
        n_chk++;
        if (s_ovr !== 1) $display("FAIL ovr_count got %0d want 1", s_ovr);
        else n_pass++;
        n_chk++;
        if ({DVALID, DOUT} !== 5'h13)
            $display("FAIL ovr_hold got %h want 13", {DVALID, DOUT});
        else n_pass++;
        push_idle(1);
        run_q(1'b1);
        n_chk++;
        if ({DVALID, DOUT, OVR} !== 6'b0_0011_0)
            $display("FAIL ovr_drain got %b want 000110", {DVALID, DOUT, OVR});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ent_t e;
        push_frame(4'hA, 1'b0, 1'b1, 0, 0);
        run_q(1'b0);
        n_chk++;
        if ({DVALID, DOUT} !== 5'h1A)
            $display("FAIL b2b_first got %h want 1a", {DVALID, DOUT});
        else n_pass++;
        clr_stats();
        push_frame(4'h6, 1'b0, 1'b1, 0, 0);
        while (q.size() > 0) begin
            e = q.pop_front();
            clk_step(e, e.en && e.ev == EV_GOOD);
        end
        n_chk++;
        if ({DVALID, DOUT} !== 5'h16)
            $display("FAIL b2b_load got %h want 16", {DVALID, DOUT});
        else n_pass++;
        n_chk++;
        if (s_dv !== 7) $display("FAIL b2b_held got %0d want 7", s_dv);
        else n_pass++;
        n_chk++;
        if (s_ovr !== 0) $display("FAIL b2b_ovr got %0d want 0", s_ovr);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        ent_t e;
        push_bit(1'b0, EV_NONE, 1'b1, 4'h0, 3);
        push_bit(1'b1, EV_NONE, 1'b1, 4'h0, 3);
        run_q(1'b0);
        for (int i = 0; i < 2; i++) begin
            e.sin = 1'b0; e.en = 1'b0; e.ev = EV_NONE;
            e.busy = 1'b1; e.d = 4'h0;
            clk_step(e, 1'b0);
        end
        n_chk++;
        if ({BUSY, DVALID} !== 2'b11)
            $display("FAIL mrst_pre got %b want 11", {BUSY, DVALID});
        else n_pass++;
        #2;
        RN = 1'b0;
        #1;
        n_chk++;
        if ({DOUT, DVALID, PERR, FERR, OVR, BUSY} !== 9'h0)
            $display("FAIL mrst_async got %h want 000",
                     {DOUT, DVALID, PERR, FERR, OVR, BUSY});
        else n_pass++;
        model_reset();
        e.sin = 1'b0; e.en = 1'b1; e.ev = EV_NONE; e.busy = 1'b0; e.d = 4'h0;
        clk_step(e, 1'b1);
        n_chk++;
        if ({DOUT, DVALID, PERR, FERR, OVR, BUSY} !== 9'h0)
            $display("FAIL mrst_held got %h want 000",
                     {DOUT, DVALID, PERR, FERR, OVR, BUSY});
        else n_pass++;
        RN = 1'b1;
        clr_stats();
        push_frame(4'h9, 1'b0, 1'b1, 3, 0);
        push_idle(2);
        run_q(1'b1);
        n_chk++;
        if ({s_dv, s_dout} !== {32'd1, 4'h9})
            $display("FAIL mrst_frame got dv=%0d dout=%h want 1/9", s_dv, s_dout);
        else n_pass++;
        n_chk++;
        if (s_perr + s_ferr + s_ovr !== 0)
            $display("FAIL mrst_errs got %0d want 0", s_perr + s_ferr + s_ovr);
        else n_pass++;
    endtask

    task automatic test_random();
        ent_t       e;
        logic [3:0] d;
        logic       pbit, sbit;
        logic [8:0] got, exp;
        for (int k = 0; k < 60; k++) begin
            d    = 4'($urandom);
            pbit = (^d) ^ ($urandom_range(0, 4) == 0);
            sbit = ($urandom_range(0, 6) != 0);
            push_frame(d, pbit, sbit, $urandom_range(0, 3), $urandom_range(0, 4));
            push_idle($urandom_range(0, 2));
            while (q.size() > 0) begin
                e = q.pop_front();
                clk_step(e, $urandom_range(0, 1) == 1);
                got = {DVALID, DOUT, PERR, FERR, OVR, BUSY};
                exp = {m_valid, m_dout, m_perr, m_ferr, m_ovr, m_busy};
                n_chk++;
                if (got !== exp)
                    $display("FAIL rand_f%0d got %b want %b", k, got, exp);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_parity();
        test_break();
        test_overrun();
        test_back_to_back();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
